// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - split request/response data-memory bus between the MEM stage and data RAM
interface mem_access_stage_if;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req,
      output data_wr,
      output data_wstrb,
      output data_addr,
      output data_wdata,
      input  data_addr_ok,
      input  data_data_ok,
      input  data_rdata
   );

   modport slave (
      input  data_req,
      input  data_wr,
      input  data_wstrb,
      input  data_addr,
      input  data_wdata,
      output data_addr_ok,
      output data_data_ok,
      output data_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: issues one data-memory access per load/store,
// extracts/extends load data and hands the write-back bundle to WB with a forwarding tap to ID.
module mem_access_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                es_to_ms_valid,
   input  logic [31:0]         es_pc,
   input  logic [3:0]          es_mem_op,
   input  logic [31:0]         es_sram_addr,
   input  logic [31:0]         es_sram_wdata,
   input  logic [3:0]          es_rf_we,
   input  logic [4:0]          es_rf_waddr,
   input  logic [31:0]         es_rf_wdata,
   output logic                ms_allow_in,
   mem_access_stage_if.master  dmem,
   input  logic                ws_allow_in,
   output logic                ms_to_ws_valid,
   output logic [31:0]         ms_pc,
   output logic [3:0]          ms_rf_we,
   output logic [4:0]          ms_rf_waddr,
   output logic [31:0]         ms_rf_wdata,
   output logic                ms_fwd_valid,
   output logic                ms_load_pend
);
   localparam logic [3:0] OP_NONE  = 4'b0000;
   localparam logic [3:0] OP_ST_B  = 4'b0001;
   localparam logic [3:0] OP_ST_H  = 4'b0010;
   localparam logic [3:0] OP_LD_B  = 4'b1000;
   localparam logic [3:0] OP_LD_H  = 4'b1001;
   localparam logic [3:0] OP_LD_BU = 4'b1100;
   localparam logic [3:0] OP_LD_HU = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t      state;
   logic        ms_valid;
   logic [3:0]  ms_mem_op;
   logic [1:0]  ms_addr_lo;

   logic        ms_is_mem;
   logic        ms_is_load;
   logic        ms_ready_go;
   logic        accept;
   logic        es_is_mem;
   logic        es_is_store;
   logic [3:0]  es_wstrb;
   logic [31:0] es_wdata_lanes;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_result;

   assign ms_is_mem      = (ms_mem_op != OP_NONE);
   assign ms_is_load     = ms_mem_op[3];
   assign ms_ready_go    = !ms_is_mem || (state == S_DONE);
   assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
   assign accept         = es_to_ms_valid && ms_allow_in;
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign ms_fwd_valid   = ms_to_ws_valid && (|ms_rf_we);
   // A latched load is pending from acceptance until its data has been captured (DONE).
   assign ms_load_pend   = ms_valid && ms_is_load && (state != S_DONE);

   assign es_is_mem      = (es_mem_op != OP_NONE);
   assign es_is_store    = es_is_mem && !es_mem_op[3];

   // Store lane steering is computed from the EXE fields so the request registers load in one shot.
   always_comb begin
      es_wstrb       = 4'b0000;
      es_wdata_lanes = 32'h0;
      if (es_is_store) begin
         case (es_mem_op)
            OP_ST_B: begin
               es_wstrb       = 4'b0001 << es_sram_addr[1:0];
               es_wdata_lanes = {4{es_sram_wdata[7:0]}};
            end
            OP_ST_H: begin
               es_wstrb       = 4'b0011 << {es_sram_addr[1], 1'b0};
               es_wdata_lanes = {2{es_sram_wdata[15:0]}};
            end
            default: begin
               es_wstrb       = 4'b1111;
               es_wdata_lanes = es_sram_wdata;
            end
         endcase
      end
   end

   always_comb begin
      load_byte   = dmem.data_rdata[7:0];
      load_half   = dmem.data_rdata[15:0];
      load_result = dmem.data_rdata;
      case (ms_addr_lo)
         2'd0:    load_byte = dmem.data_rdata[7:0];
         2'd1:    load_byte = dmem.data_rdata[15:8];
         2'd2:    load_byte = dmem.data_rdata[23:16];
         default: load_byte = dmem.data_rdata[31:24];
      endcase
      // Halfword lane follows addr[1] only; a misaligned addr[0] is ignored.
      if (ms_addr_lo[1]) begin
         load_half = dmem.data_rdata[31:16];
      end
      case (ms_mem_op)
         OP_LD_B:  load_result = {{24{load_byte[7]}}, load_byte};
         OP_LD_BU: load_result = {24'h0, load_byte};
         OP_LD_H:  load_result = {{16{load_half[15]}}, load_half};
         OP_LD_HU: load_result = {16'h0, load_half};
         default:  load_result = dmem.data_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         ms_valid        <= 1'b0;
         ms_mem_op       <= OP_NONE;
         ms_addr_lo      <= 2'b00;
         ms_pc           <= RESET_PC;
         ms_rf_we        <= 4'b0000;
         ms_rf_waddr     <= 5'd0;
         ms_rf_wdata     <= 32'h0;
         dmem.data_req   <= 1'b0;
         dmem.data_wr    <= 1'b0;
         dmem.data_wstrb <= 4'b0000;
         dmem.data_addr  <= 32'h0;
         dmem.data_wdata <= 32'h0;
      end else begin
         if (ms_allow_in) begin
            ms_valid <= es_to_ms_valid;
         end
         if (accept) begin
            ms_pc       <= es_pc;
            ms_mem_op   <= es_mem_op;
            ms_addr_lo  <= es_sram_addr[1:0];
            ms_rf_we    <= es_is_store ? 4'b0000 : es_rf_we;
            ms_rf_waddr <= es_rf_waddr;
            ms_rf_wdata <= es_rf_wdata;
         end

         case (state)
            S_IDLE, S_DONE: begin
               // A mem op accepted here (including the cycle WB drains DONE) issues immediately.
               if (accept && es_is_mem) begin
                  state           <= S_REQ;
                  dmem.data_req   <= 1'b1;
                  dmem.data_wr    <= es_is_store;
                  dmem.data_wstrb <= es_wstrb;
                  dmem.data_addr  <= {es_sram_addr[31:2], 2'b00};
                  dmem.data_wdata <= es_wdata_lanes;
               end else if ((state == S_DONE) && ws_allow_in) begin
                  state <= S_IDLE;
               end
            end
            S_REQ: begin
               if (dmem.data_addr_ok) begin
                  state         <= S_WAIT;
                  dmem.data_req <= 1'b0;
               end
            end
            S_WAIT: begin
               if (dmem.data_data_ok) begin
                  state <= S_DONE;
                  if (ms_is_load) begin
                     ms_rf_wdata <= load_result;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and randomized checks of mem_access_stage against a
// sequential instruction/memory reference model.
module tb_mem_access_stage;
   localparam logic [31:0] RESET_PC = 32'h1c000000;
   localparam logic [3:0] ALU = 4'b0000, ST_B = 4'b0001, ST_H = 4'b0010, ST_W = 4'b0011;
   localparam logic [3:0] LD_B = 4'b1000, LD_H = 4'b1001, LD_W = 4'b1010, LD_BU = 4'b1100, LD_HU = 4'b1101;
   localparam int N = 60;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  we;
      logic [4:0]  waddr;
      logic [31:0] alu;
   } instr_t;
   typedef struct {
      logic [31:0] wr;
      logic [31:0] wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] we;
      logic [31:0] waddr;
      logic [31:0] wdata;
   } wb_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        es_to_ms_valid;
   logic [31:0] es_pc;
   logic [3:0]  es_mem_op;
   logic [31:0] es_sram_addr;
   logic [31:0] es_sram_wdata;
   logic [3:0]  es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [31:0] es_rf_wdata;
   logic        ms_allow_in;
   logic        ws_allow_in;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic [3:0]  ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic        ms_fwd_valid;
   logic        ms_load_pend;

   mem_access_stage_if dmem ();

   mem_access_stage #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .es_to_ms_valid (es_to_ms_valid),
      .es_pc          (es_pc),
      .es_mem_op      (es_mem_op),
      .es_sram_addr   (es_sram_addr),
      .es_sram_wdata  (es_sram_wdata),
      .es_rf_we       (es_rf_we),
      .es_rf_waddr    (es_rf_waddr),
      .es_rf_wdata    (es_rf_wdata),
      .ms_allow_in    (ms_allow_in),
      .dmem           (dmem),
      .ws_allow_in    (ws_allow_in),
      .ms_to_ws_valid (ms_to_ws_valid),
      .ms_pc          (ms_pc),
      .ms_rf_we       (ms_rf_we),
      .ms_rf_waddr    (ms_rf_waddr),
      .ms_rf_wdata    (ms_rf_wdata),
      .ms_fwd_valid   (ms_fwd_valid),
      .ms_load_pend   (ms_load_pend)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   instr_t      prog [N];
   req_t        exp_req [$];
   wb_t         exp_wb [$];
   logic [31:0] model_mem [16];
   logic [31:0] dev_mem [16];
   logic [3:0]  op_tab [9];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic exe(input logic [31:0] pc, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] we, input logic [4:0] wa,
                      input logic [31:0] alu);
      es_to_ms_valid = 1'b1;
      es_pc          = pc;
      es_mem_op      = op;
      es_sram_addr   = addr;
      es_sram_wdata  = wd;
      es_rf_we       = we;
      es_rf_waddr    = wa;
      es_rf_wdata    = alu;
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [3:0] op,
                                            input logic [1:0] lo);
      logic [31:0] b;
      logic [31:0] h;
      b = (word >> (8 * lo)) & 32'hff;
      h = (word >> (16 * lo[1])) & 32'hffff;
      case (op)
         LD_B:    return (b > 32'h7f) ? (b | 32'hffffff00) : b;
         LD_BU:   return b;
         LD_H:    return (h > 32'h7fff) ? (h | 32'hffff0000) : h;
         LD_HU:   return h;
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [3:0] op,
                                             input logic [1:0] lo, input logic [31:0] wd);
      int unsigned sh;
      logic [31:0] mask;
      case (op)
         ST_B: begin
            sh   = 8 * lo;
            mask = 32'hff << sh;
            return (word & ~mask) | ((wd & 32'hff) << sh);
         end
         ST_H: begin
            sh   = 16 * lo[1];
            mask = 32'hffff << sh;
            return (word & ~mask) | ((wd & 32'hffff) << sh);
         end
         default: return wd;
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: observed simulation time limit, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t      t;
      req_t        r;
      wb_t         w;
      logic [3:0]  idx;
      logic        is_st;
      logic        taken;
      int          next_in;
      int          n_done;
      int          resp_wait;
      logic [31:0] resp_data;

      reset = 1'b1;
      ws_allow_in = 1'b1;
      es_to_ms_valid = 1'b0;
      es_pc = 32'h0; es_mem_op = ALU; es_sram_addr = 32'h0; es_sram_wdata = 32'h0;
      es_rf_we = 4'h0; es_rf_waddr = 5'd0; es_rf_wdata = 32'h0;
      dmem.data_addr_ok = 1'b0; dmem.data_data_ok = 1'b0; dmem.data_rdata = 32'h0;
      tick;
      tick;
      chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 0);
      chk("rst_pc", ms_pc, RESET_PC);
      chk("rst_rf_we", 32'(ms_rf_we), 0);
      chk("rst_rf_waddr", 32'(ms_rf_waddr), 0);
      chk("rst_rf_wdata", ms_rf_wdata, 0);
      chk("rst_req", 32'(dmem.data_req), 0);
      chk("rst_wr", 32'(dmem.data_wr), 0);
      chk("rst_wstrb", 32'(dmem.data_wstrb), 0);
      chk("rst_addr", dmem.data_addr, 0);
      chk("rst_wdata", dmem.data_wdata, 0);
      chk("rst_fwd", 32'(ms_fwd_valid), 0);
      chk("rst_load_pend", 32'(ms_load_pend), 0);
      chk("rst_allow_in", 32'(ms_allow_in), 1);
      reset = 1'b0;

      // 1. ALU op passes straight through
      exe(32'h1c000010, ALU, 32'h0, 32'h0, 4'hf, 5'd5, 32'h00001234);
      #1;
      chk("alu_allow_in", 32'(ms_allow_in), 1);
      tick;
      es_to_ms_valid = 1'b0;
      #1;
      chk("alu_to_ws_valid", 32'(ms_to_ws_valid), 1);
      chk("alu_wdata", ms_rf_wdata, 32'h00001234);
      chk("alu_waddr", 32'(ms_rf_waddr), 5);
      chk("alu_pc", ms_pc, 32'h1c000010);
      chk("alu_no_req", 32'(dmem.data_req), 0);
      chk("alu_fwd", 32'(ms_fwd_valid), 1);
      tick;

      // 2. ld.b at 0x103, data_ok three cycles after addr_ok
      exe(32'h1c000020, LD_B, 32'h00000103, 32'h0, 4'hf, 5'd7, 32'hdeadbeef);
      tick;
      es_to_ms_valid = 1'b0;
      dmem.data_addr_ok = 1'b1;
      #1;
      chk("ldb_req", 32'(dmem.data_req), 1);
      chk("ldb_wr", 32'(dmem.data_wr), 0);
      chk("ldb_addr", dmem.data_addr, 32'h00000100);
      chk("ldb_wstrb", 32'(dmem.data_wstrb), 0);
      chk("ldb_pend_req", 32'(ms_load_pend), 1);
      chk("ldb_allow_in", 32'(ms_allow_in), 0);
      tick;
      dmem.data_addr_ok = 1'b0;
      #1;
      chk("ldb_req_dropped", 32'(dmem.data_req), 0);
      for (int i = 0; i < 2; i++) begin
         chk("ldb_pend_wait", 32'(ms_load_pend), 1);
         chk("ldb_not_valid", 32'(ms_to_ws_valid), 0);
         tick;
      end
      dmem.data_data_ok = 1'b1;
      dmem.data_rdata = 32'h80000000;
      #1;
      chk("ldb_pend_dataok", 32'(ms_load_pend), 1);
      tick;
      dmem.data_data_ok = 1'b0;
      dmem.data_rdata = 32'h0;
      #1;
      chk("ldb_to_ws_valid", 32'(ms_to_ws_valid), 1);
      chk("ldb_wdata", ms_rf_wdata, 32'hffffff80);
      chk("ldb_pend_done", 32'(ms_load_pend), 0);
      chk("ldb_fwd", 32'(ms_fwd_valid), 1);
      tick;
      chk("ldb_retired", 32'(ms_to_ws_valid), 0);

      // 3. st.h at 0x106
      exe(32'h1c000030, ST_H, 32'h00000106, 32'h0000abcd, 4'hf, 5'd9, 32'h00000055);
      tick;
      es_to_ms_valid = 1'b0;
      dmem.data_addr_ok = 1'b1;
      #1;
      chk("sth_wr", 32'(dmem.data_wr), 1);
      chk("sth_wstrb", 32'(dmem.data_wstrb), 32'hc);
      chk("sth_wdata", dmem.data_wdata, 32'habcdabcd);
      chk("sth_addr", dmem.data_addr, 32'h00000104);
      chk("sth_rf_we", 32'(ms_rf_we), 0);
      tick;
      dmem.data_addr_ok = 1'b0;
      dmem.data_data_ok = 1'b1;
      #1;
      chk("sth_wait_not_valid", 32'(ms_to_ws_valid), 0);
      tick;
      dmem.data_data_ok = 1'b0;
      #1;
      chk("sth_to_ws_valid", 32'(ms_to_ws_valid), 1);
      chk("sth_fwd", 32'(ms_fwd_valid), 0);
      chk("sth_wb_data", ms_rf_wdata, 32'h00000055);
      tick;

      // 4. addr_ok withheld for 4 cycles while EXE offers the next instruction
      exe(32'h1c000040, LD_W, 32'h00000208, 32'h0, 4'hf, 5'd3, 32'h0);
      tick;
      exe(32'h1c000abc, ALU, 32'h0, 32'h0, 4'hf, 5'd4, 32'h00000777);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_req", 32'(dmem.data_req), 1);
         chk("stall_addr", dmem.data_addr, 32'h00000208);
         chk("stall_wstrb", 32'(dmem.data_wstrb), 0);
         chk("stall_allow_in", 32'(ms_allow_in), 0);
         chk("stall_pc", ms_pc, 32'h1c000040);
         tick;
      end
      dmem.data_addr_ok = 1'b1;
      tick;
      dmem.data_addr_ok = 1'b0;
      #1;
      chk("stall_req_once", 32'(dmem.data_req), 0);
      chk("stall_pc_kept", ms_pc, 32'h1c000040);
      dmem.data_data_ok = 1'b1;
      dmem.data_rdata = 32'h12345678;
      tick;
      dmem.data_data_ok = 1'b0;
      #1;
      chk("stall_wdata", ms_rf_wdata, 32'h12345678);
      chk("stall_allow_done", 32'(ms_allow_in), 1);
      tick;
      es_to_ms_valid = 1'b0;
      #1;
      chk("stall_next_pc", ms_pc, 32'h1c000abc);
      chk("stall_next_valid", 32'(ms_to_ws_valid), 1);
      chk("stall_next_wdata", ms_rf_wdata, 32'h00000777);
      chk("stall_next_no_req", 32'(dmem.data_req), 0);
      tick;

      // 5. WB back-pressure in DONE with a ld.hu queued behind
      exe(32'h1c000050, LD_W, 32'h00000300, 32'h0, 4'hf, 5'd10, 32'h0);
      tick;
      es_to_ms_valid = 1'b0;
      dmem.data_addr_ok = 1'b1;
      tick;
      dmem.data_addr_ok = 1'b0;
      dmem.data_data_ok = 1'b1;
      dmem.data_rdata = 32'hcafebabe;
      tick;
      dmem.data_data_ok = 1'b0;
      ws_allow_in = 1'b0;
      exe(32'h1c000054, LD_HU, 32'h00000102, 32'h0, 4'hf, 5'd11, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_valid", 32'(ms_to_ws_valid), 1);
         chk("bp_wdata", ms_rf_wdata, 32'hcafebabe);
         chk("bp_pc", ms_pc, 32'h1c000050);
         chk("bp_allow_in", 32'(ms_allow_in), 0);
         chk("bp_no_req", 32'(dmem.data_req), 0);
         tick;
      end
      ws_allow_in = 1'b1;
      #1;
      chk("bp_release_allow", 32'(ms_allow_in), 1);
      tick;
      es_to_ms_valid = 1'b0;
      dmem.data_addr_ok = 1'b1;
      #1;
      chk("bp_second_req", 32'(dmem.data_req), 1);
      chk("bp_second_addr", dmem.data_addr, 32'h00000100);
      chk("bp_second_pc", ms_pc, 32'h1c000054);
      chk("bp_second_not_valid", 32'(ms_to_ws_valid), 0);
      tick;
      dmem.data_addr_ok = 1'b0;
      dmem.data_data_ok = 1'b1;
      dmem.data_rdata = 32'hf00d0000;
      tick;
      dmem.data_data_ok = 1'b0;
      #1;
      chk("bp_hu_wdata", ms_rf_wdata, 32'h0000f00d);
      chk("bp_hu_valid", 32'(ms_to_ws_valid), 1);
      tick;

      // 6. reset while waiting for data, then a late data_ok
      exe(32'h1c000060, LD_W, 32'h00000400, 32'h0, 4'hf, 5'd12, 32'h0);
      tick;
      es_to_ms_valid = 1'b0;
      dmem.data_addr_ok = 1'b1;
      tick;
      dmem.data_addr_ok = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      #1;
      chk("rw_valid", 32'(ms_to_ws_valid), 0);
      chk("rw_req", 32'(dmem.data_req), 0);
      chk("rw_pend", 32'(ms_load_pend), 0);
      chk("rw_allow_in", 32'(ms_allow_in), 1);
      chk("rw_pc", ms_pc, RESET_PC);
      dmem.data_data_ok = 1'b1;
      dmem.data_rdata = 32'h00000bad;
      tick;
      dmem.data_data_ok = 1'b0;
      #1;
      chk("rw_late_valid", 32'(ms_to_ws_valid), 0);
      chk("rw_late_req", 32'(dmem.data_req), 0);
      tick;
      chk("rw_late_valid2", 32'(ms_to_ws_valid), 0);

      // 7. data_ok during REQ is ignored
      exe(32'h1c000070, LD_BU, 32'h00000501, 32'h0, 4'h1, 5'd2, 32'h0);
      tick;
      es_to_ms_valid = 1'b0;
      dmem.data_data_ok = 1'b1;
      dmem.data_rdata = 32'h0000ff00;
      tick;
      dmem.data_data_ok = 1'b0;
      #1;
      chk("early_req_held", 32'(dmem.data_req), 1);
      chk("early_not_valid", 32'(ms_to_ws_valid), 0);
      chk("early_pend", 32'(ms_load_pend), 1);
      dmem.data_addr_ok = 1'b1;
      tick;
      dmem.data_addr_ok = 1'b0;
      dmem.data_data_ok = 1'b1;
      dmem.data_rdata = 32'h00003400;
      tick;
      dmem.data_data_ok = 1'b0;
      #1;
      chk("early_bu_wdata", ms_rf_wdata, 32'h00000034);
      chk("early_bu_valid", 32'(ms_to_ws_valid), 1);
      tick;

      // Randomized program checked against a sequential reference model
      op_tab = '{ALU, ALU, ST_B, ST_H, ST_W, LD_B, LD_H, LD_W, LD_BU};
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = $urandom;
         dev_mem[i]   = model_mem[i];
      end
      for (int i = 0; i < N; i++) begin
         t.pc    = 32'h1c001000 + 32'(i * 4);
         t.op    = ($urandom_range(0, 9) == 9) ? LD_HU : op_tab[$urandom_range(0, 8)];
         t.addr  = 32'h00001000 | 32'($urandom_range(0, 63));
         t.wd    = $urandom;
         t.we    = 4'($urandom_range(0, 15));
         t.waddr = 5'($urandom_range(0, 31));
         t.alu   = $urandom;
         prog[i] = t;
         idx     = t.addr[5:2];
         is_st   = (t.op != ALU) && !t.op[3];
         w.pc    = t.pc;
         w.we    = is_st ? 32'h0 : 32'(t.we);
         w.waddr = 32'(t.waddr);
         w.wdata = t.op[3] ? ref_load(model_mem[idx], t.op, t.addr[1:0]) : t.alu;
         exp_wb.push_back(w);
         if (t.op != ALU) begin
            r.wr    = is_st ? 32'h1 : 32'h0;
            r.addr  = t.addr & 32'hfffffffc;
            r.wstrb = !is_st ? 32'h0 : (t.op == ST_B) ? (32'h1 << t.addr[1:0]) :
                      (t.op == ST_H) ? (32'h3 << (t.addr[1:0] & 2'b10)) : 32'hf;
            r.wdata = (t.op == ST_B) ? (t.wd & 32'hff) * 32'h01010101 :
                      (t.op == ST_H) ? (t.wd & 32'hffff) * 32'h00010001 : t.wd;
            exp_req.push_back(r);
            if (is_st) model_mem[idx] = ref_store(model_mem[idx], t.op, t.addr[1:0], t.wd);
         end
      end

      reset = 1'b1;
      es_to_ms_valid = 1'b0;
      dmem.data_addr_ok = 1'b0;
      dmem.data_data_ok = 1'b0;
      tick;
      reset = 1'b0;
      taken = 1'b0;
      next_in = 0;
      n_done = 0;
      resp_wait = -1;
      resp_data = 32'h0;
      for (int cyc = 0; cyc < 4000 && n_done < N; cyc++) begin
         if (taken) begin
            es_to_ms_valid = 1'b0;
            next_in++;
            taken = 1'b0;
         end
         if (!es_to_ms_valid && next_in < N && $urandom_range(0, 2) != 0) begin
            t = prog[next_in];
            exe(t.pc, t.op, t.addr, t.wd, t.we, t.waddr, t.alu);
         end
         ws_allow_in = ($urandom_range(0, 3) != 0);
         dmem.data_addr_ok = dmem.data_req && ($urandom_range(0, 1) == 1);
         if (resp_wait == 0) begin
            dmem.data_data_ok = 1'b1;
            dmem.data_rdata = resp_data;
            resp_wait = -1;
         end else begin
            dmem.data_data_ok = 1'b0;
            dmem.data_rdata = $urandom;
         end
         #1;
         if (es_to_ms_valid && ms_allow_in) taken = 1'b1;
         if (dmem.data_req && dmem.data_addr_ok) begin
            chk("rand_req_queued", 32'(exp_req.size() != 0), 1);
            if (exp_req.size() != 0) begin
               r = exp_req.pop_front();
               chk("rand_req_wr", 32'(dmem.data_wr), r.wr);
               chk("rand_req_addr", dmem.data_addr, r.addr);
               chk("rand_req_wstrb", 32'(dmem.data_wstrb), r.wstrb);
               if (r.wr == 32'h1) chk("rand_req_wdata", dmem.data_wdata, r.wdata);
            end
            idx = dmem.data_addr[5:2];
            if (dmem.data_wr) begin
               for (int b = 0; b < 4; b++)
                  if (dmem.data_wstrb[b]) dev_mem[idx][8*b +: 8] = dmem.data_wdata[8*b +: 8];
               resp_data = $urandom;
            end else begin
               resp_data = dev_mem[idx];
            end
            resp_wait = $urandom_range(1, 3);
         end
         if (ms_to_ws_valid && ws_allow_in) begin
            chk("rand_wb_queued", 32'(exp_wb.size() != 0), 1);
            if (exp_wb.size() != 0) begin
               w = exp_wb.pop_front();
               chk("rand_wb_pc", ms_pc, w.pc);
               chk("rand_wb_we", 32'(ms_rf_we), w.we);
               chk("rand_wb_waddr", 32'(ms_rf_waddr), w.waddr);
               chk("rand_wb_wdata", ms_rf_wdata, w.wdata);
            end
            n_done++;
         end
         if (resp_wait > 0) resp_wait--;
         tick;
      end
      chk("rand_all_retired", 32'(n_done), 32'(N));
      chk("rand_reqs_consumed", 32'(exp_req.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
